if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: Stall  in  1  hazard unit; hold PC and IF/ID; redirect inputs ignored while high.
REQ-004 SHALL have: Jump  in  2  00 none, 01 J/JAL (JumpTarget), 10 JR/JALR (JrTarget), 11 treated as 00.
REQ-005 SHALL have: Branch  in  1, BranchCond  in  1  (branch taken = Branch & BranchCond & Jump==00).
REQ-006 SHALL have: JumpTarget  in  32  J/branch target; JrTarget  in  32  register jump target.
REQ-007 SHALL have: Exception  in  1, Interrupt  in  1  from ID.
REQ-008 SHALL have: InstReq  out  1, InstAddr  out  32  fetch request to instruction memory.
REQ-009 SHALL have: InstValid  in  1, InstData  in  32  response, one or more cycles after the request.
REQ-010 SHALL have: IFID_Instruction  out  32, IFID_PC  out  32 (address of that instruction), IFID_Valid  out  1.

Function
REQ-011 Redirect SHALL be evaluated only when Stall=0, priority: Exception -> 0x80000008; Interrupt with PC[31]=0 -> 0x80000004; Jump 01 -> JumpTarget; Jump 10 -> JrTarget; taken branch -> JumpTarget.
REQ-012 Interrupt SHALL be ignored while PC[31]=1 (kernel mode).
REQ-013 At most one memory request SHALL be outstanding; InstReq is a one-cycle pulse per request.
REQ-014 FSM states SHALL be REQ, WAIT, HOLD, DISCARD.
REQ-015 REQ: InstReq=1, InstAddr=PC; with redirect, PC<=target and next DISCARD; otherwise next WAIT.
REQ-016 WAIT, InstValid=1 with redirect: response dropped, PC<=target, next REQ.
REQ-017 WAIT, InstValid=1, Stall=1: InstData and PC captured in hold buffer, next HOLD.
REQ-018 WAIT, InstValid=1, Stall=0, no redirect: IF/ID<=(InstData, PC, 1); PC<=PC+4; same cycle InstReq=1, InstAddr=PC+4; stay WAIT (one instruction per cycle with 1-cycle memory).
REQ-019 WAIT, InstValid=0: redirect gives PC<=target and next DISCARD; otherwise stay.
REQ-020 HOLD: Stall=0 without redirect loads IF/ID from buffer, PC<=PC+4, next REQ; Stall=0 with redirect drops buffer, PC<=target, next REQ.
REQ-021 DISCARD: in-flight response dropped on InstValid, next REQ; a further redirect updates PC (latest wins) and stays DISCARD.
REQ-022 Whenever Stall=0 and no instruction loads IF/ID (including every redirect cycle), IF/ID SHALL become bubble: IFID_Valid=0, IFID_Instruction=0x00000000.
REQ-023 Stall=1 SHALL hold IFID_* unchanged.
REQ-024 PC arithmetic SHALL be 32-bit modulo 2^32; PC[1:0] not checked.
REQ-025 InstValid in state REQ or HOLD SHALL be ignored (protocol violation).

Reset
REQ-026 reset low SHALL asynchronously set PC=0x80000000, state=REQ, IFID_Valid=0, IFID_Instruction=0, IFID_PC=0, hold buffer=0.
REQ-027 InstReq SHALL be 0 while reset is low; first request, addr 0x80000000, in the first cycle after release.
REQ-028 Responses to requests issued before a mid-operation reset SHALL be ignored after reset (first state REQ).

Structure
REQ-029 Shared package SHALL hold: reset vector 0x80000000, interrupt vector 0x80000004, exception vector 0x80000008, NOP encoding, FSM state encoding, Jump encodings.
REQ-030 Next-PC priority select SHALL be a combinational sub-module pc_next_sel; FSM, PC and IF/ID registers stay in if_stage.

Verification
REQ-031 Reset release, 1-cycle memory returning addr as data -> IFID_PC 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, IFID_Valid=1.
REQ-032 Stall=1 on the cycle InstValid returns 0x80000004 -> IF/ID frozen, state HOLD; Stall drop -> IFID_PC=0x80000004 next cycle, then fetch 0x80000008.
REQ-033 Jump=01, JumpTarget=0x00400010 during WAIT with InstValid=0 -> IF/ID bubble, late response dropped, next InstAddr=0x00400010.
REQ-034 Exception=1 and Jump=10 same cycle -> next fetch 0x80000008; Interrupt=1 with PC=0x80000020 -> no redirect.
REQ-035 Branch=1, BranchCond=1, Stall=1 -> no redirect; Stall=0 next cycle -> fetch JumpTarget.
REQ-036 reset low while state WAIT -> outputs reset immediately, stale InstValid ignored, refetch from 0x80000000.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants and encodings for the instruction-fetch stage.
package if_stage_pkg;

   localparam logic [31:0] RESET_VEC = 32'h8000_0000;
   localparam logic [31:0] INT_VEC   = 32'h8000_0004;
   localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_REQ     = 2'd0,
      ST_WAIT    = 2'd1,
      ST_HOLD    = 2'd2,
      ST_DISCARD = 2'd3
   } fetch_state_t;

   typedef enum logic [1:0] {
      JMP_NONE = 2'b00,
      JMP_J    = 2'b01,
      JMP_JR   = 2'b10,
      JMP_RSVD = 2'b11
   } jump_t;

endpackage

// File: rtl/if_stage_pc_next_sel.sv
// Priority select of the redirect target; purely combinational.
module pc_next_sel
   import if_stage_pkg::*;
(
   input  logic        stall,
   input  logic        kernel_mode,
   input  logic [1:0]  jump,
   input  logic        branch,
   input  logic        branch_cond,
   input  logic [31:0] jump_target,
   input  logic [31:0] jr_target,
   input  logic        exception,
   input  logic        interrupt,
   output logic        redirect,
   output logic [31:0] target
);

   // Reserved jump encoding behaves exactly like "no jump", branches included.
   logic jump_none;
   assign jump_none = (jump == JMP_NONE) || (jump == JMP_RSVD);

   always_comb begin
      redirect = 1'b0;
      target   = jump_target;
      if (!stall) begin
         if (exception) begin
            redirect = 1'b1;
            target   = EXC_VEC;
         end else if (interrupt && !kernel_mode) begin
            redirect = 1'b1;
            target   = INT_VEC;
         end else if (jump == JMP_J) begin
            redirect = 1'b1;
            target   = jump_target;
         end else if (jump == JMP_JR) begin
            redirect = 1'b1;
            target   = jr_target;
         end else if (branch && branch_cond && jump_none) begin
            redirect = 1'b1;
            target   = jump_target;
         end
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: single-outstanding request FSM, PC register and IF/ID pipeline register.
module if_stage
   import if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall,
   input  logic [1:0]  Jump,
   input  logic        Branch,
   input  logic        BranchCond,
   input  logic [31:0] JumpTarget,
   input  logic [31:0] JrTarget,
   input  logic        Exception,
   input  logic        Interrupt,
   output logic        InstReq,
   output logic [31:0] InstAddr,
   input  logic        InstValid,
   input  logic [31:0] InstData,
   output logic [31:0] IFID_Instruction,
   output logic [31:0] IFID_PC,
   output logic        IFID_Valid
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  hold_instr;
   logic [31:0]  hold_pc;
   logic         redirect;
   logic [31:0]  target;
   logic         accept;
   logic [31:0]  pc_plus4;

   pc_next_sel u_sel (
      .stall       (Stall),
      .kernel_mode (pc[31]),
      .jump        (Jump),
      .branch      (Branch),
      .branch_cond (BranchCond),
      .jump_target (JumpTarget),
      .jr_target   (JrTarget),
      .exception   (Exception),
      .interrupt   (Interrupt),
      .redirect    (redirect),
      .target      (target)
   );

   assign pc_plus4 = pc + 32'd4;
   // redirect already implies Stall=0
   assign accept   = (state == ST_WAIT) && InstValid && !Stall && !redirect;

   // Back-to-back fetch: the next request goes out in the same cycle the response is consumed.
   assign InstReq  = reset && ((state == ST_REQ) || accept);
   assign InstAddr = accept ? pc_plus4 : pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= ST_REQ;
         pc               <= RESET_VEC;
         hold_instr       <= 32'h0;
         hold_pc          <= 32'h0;
         IFID_Valid       <= 1'b0;
         IFID_Instruction <= NOP_INSTR;
         IFID_PC          <= 32'h0;
      end else begin
         if (!Stall) begin
            IFID_Valid       <= 1'b0;
            IFID_Instruction <= NOP_INSTR;
         end
         case (state)
            ST_REQ: begin
               if (redirect) begin
                  pc    <= target;
                  state <= ST_DISCARD;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (InstValid) begin
                  if (redirect) begin
                     pc    <= target;
                     state <= ST_REQ;
                  end else if (Stall) begin
                     hold_instr <= InstData;
                     hold_pc    <= pc;
                     state      <= ST_HOLD;
                  end else begin
                     IFID_Valid       <= 1'b1;
                     IFID_Instruction <= InstData;
                     IFID_PC          <= pc;
                     pc               <= pc_plus4;
                  end
               end else if (redirect) begin
                  pc    <= target;
                  state <= ST_DISCARD;
               end
            end
            ST_HOLD: begin
               if (!Stall) begin
                  if (redirect) begin
                     pc <= target;
                  end else begin
                     IFID_Valid       <= 1'b1;
                     IFID_Instruction <= hold_instr;
                     IFID_PC          <= hold_pc;
                     pc               <= pc_plus4;
                  end
                  state <= ST_REQ;
               end
            end
            ST_DISCARD: begin
               // Latest redirect wins; leave as soon as the stale response is swallowed.
               if (redirect) pc <= target;
               if (InstValid) state <= ST_REQ;
            end
            default: state <= ST_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage plus hand-written reset sequences.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        Stall;
   logic [1:0]  Jump;
   logic        Branch, BranchCond;
   logic [31:0] JumpTarget, JrTarget;
   logic        Exception, Interrupt;
   logic        InstReq;
   logic [31:0] InstAddr;
   logic        InstValid;
   logic [31:0] InstData;
   logic [31:0] IFID_Instruction, IFID_PC;
   logic        IFID_Valid;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   if_stage dut (
      .clk              (clk),
      .reset            (reset),
      .Stall            (Stall),
      .Jump             (Jump),
      .Branch           (Branch),
      .BranchCond       (BranchCond),
      .JumpTarget       (JumpTarget),
      .JrTarget         (JrTarget),
      .Exception        (Exception),
      .Interrupt        (Interrupt),
      .InstReq          (InstReq),
      .InstAddr         (InstAddr),
      .InstValid        (InstValid),
      .InstData         (InstData),
      .IFID_Instruction (IFID_Instruction),
      .IFID_PC          (IFID_PC),
      .IFID_Valid       (IFID_Valid)
   );

   typedef struct {
      logic        st;
      logic [1:0]  jmp;
      logic        br, bc, exc, irq;
      logic [31:0] jt, jr;
      logic        iv;
      logic [31:0] id;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_v;
      logic [31:0] e_pc, e_ins;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic st, input logic [1:0] jmp, input logic br, input logic bc,
                               input logic exc, input logic irq, input logic [31:0] jt, input logic [31:0] jr,
                               input logic iv, input logic [31:0] id, input logic e_req, input logic [31:0] e_addr,
                               input logic e_v, input logic [31:0] e_pc, input logic [31:0] e_ins);
      vec_t v;
      v.st = st; v.jmp = jmp; v.br = br; v.bc = bc; v.exc = exc; v.irq = irq;
      v.jt = jt; v.jr = jr; v.iv = iv; v.id = id;
      v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_ins = e_ins;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      Stall = 0; Jump = 2'b00; Branch = 0; BranchCond = 0; Exception = 0; Interrupt = 0;
      JumpTarget = 32'h0; JrTarget = 32'h0; InstValid = 0; InstData = 32'h0;
   endtask

   logic        req_s;
   logic [31:0] addr_s;

   initial begin
      // Columns: stall jump br bc exc irq jt jr iv idata | req addr | ifid_valid ifid_pc ifid_instr
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,0,32'h0,               1,32'h80000000, 0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,1,32'h80000000,        1,32'h80000004, 1,32'h80000000,32'h80000000));
      tbl.push_back(mk(1,0,0,0,0,0,32'h0,32'h0,1,32'h80000004,        0,32'h0,        1,32'h80000000,32'h80000000));
      tbl.push_back(mk(1,0,0,0,0,0,32'h0,32'h0,0,32'h0,               0,32'h0,        1,32'h80000000,32'h80000000));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,0,32'h0,               0,32'h0,        1,32'h80000004,32'h80000004));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,0,32'h0,               1,32'h80000008, 0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,1,32'h80000008,        1,32'h8000000C, 1,32'h80000008,32'h80000008));
      tbl.push_back(mk(0,1,0,0,0,0,32'h00400010,32'h0,0,32'h0,        0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,1,32'h8000000C,        0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,0,32'h0,               1,32'h00400010, 0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,1,32'hDEAD0001,        1,32'h00400014, 1,32'h00400010,32'hDEAD0001));
      tbl.push_back(mk(0,2,0,0,1,0,32'h0,32'h12345678,0,32'h0,        0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,1,32'h0BADBAD0,        0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,0,32'h0,               1,32'h80000008, 0,32'h0,32'h0));
      tbl.push_back(mk(0,1,0,0,0,0,32'h80000020,32'h0,1,32'h0BADBAD1, 0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,1,32'h0,32'h0,0,32'h0,               1,32'h80000020, 0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,1,32'h0,32'h0,1,32'hCAFE0020,        1,32'h80000024, 1,32'h80000020,32'hCAFE0020));
      tbl.push_back(mk(1,0,1,1,0,0,32'h00001000,32'h0,0,32'h0,        0,32'h0,        1,32'h80000020,32'hCAFE0020));
      tbl.push_back(mk(0,0,1,1,0,0,32'h00001000,32'h0,0,32'h0,        0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,1,32'h0BADBAD2,        0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,0,32'h0,               1,32'h00001000, 0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,1,32'h0,32'h0,1,32'h11111111,        0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,0,32'h0,               1,32'h80000004, 0,32'h0,32'h0));
      tbl.push_back(mk(0,3,0,0,0,0,32'h00009000,32'h0,0,32'h0,        0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,0,1,0,0,0,32'h00009000,32'h0,0,32'h0,        0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,2,1,1,0,0,32'h00002000,32'h00003000,1,32'h22222222, 0,32'h0, 0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,0,32'h0,               1,32'h00003000, 0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,1,32'h33333333,        1,32'h00003004, 1,32'h00003000,32'h33333333));
      tbl.push_back(mk(1,0,0,0,0,0,32'h0,32'h0,1,32'h44444444,        0,32'h0,        1,32'h00003000,32'h33333333));
      tbl.push_back(mk(0,0,0,0,1,0,32'h0,32'h0,0,32'h0,               0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,1,32'h0BADBAD3,        1,32'h80000008, 0,32'h0,32'h0));
      tbl.push_back(mk(0,1,0,0,0,0,32'h00005000,32'h0,0,32'h0,        0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,1,0,0,0,0,32'h00006000,32'h0,0,32'h0,        0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,1,32'h0BADBAD4,        0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,0,32'h0,               1,32'h00006000, 0,32'h0,32'h0));
      tbl.push_back(mk(0,1,0,0,0,0,32'hFFFFFFFC,32'h0,1,32'h0BADBAD5, 0,32'h0,        0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,0,32'h0,               1,32'hFFFFFFFC, 0,32'h0,32'h0));
      tbl.push_back(mk(0,0,0,0,0,0,32'h0,32'h0,1,32'h66666666,        1,32'h00000000, 1,32'hFFFFFFFC,32'h66666666));

      clear_inputs();
      reset = 0;
      repeat (2) @(posedge clk);
      #3;
      chk("reset InstReq", {31'h0, InstReq}, 32'h0);
      chk("reset IFID_Valid", {31'h0, IFID_Valid}, 32'h0);
      chk("reset IFID_PC", IFID_PC, 32'h0);
      chk("reset IFID_Instruction", IFID_Instruction, 32'h0);
      reset = 1;

      foreach (tbl[i]) begin
         Stall = tbl[i].st; Jump = tbl[i].jmp; Branch = tbl[i].br; BranchCond = tbl[i].bc;
         Exception = tbl[i].exc; Interrupt = tbl[i].irq; JumpTarget = tbl[i].jt; JrTarget = tbl[i].jr;
         InstValid = tbl[i].iv; InstData = tbl[i].id;
         #1;
         chk($sformatf("row%0d InstReq", i), {31'h0, InstReq}, {31'h0, tbl[i].e_req});
         if (tbl[i].e_req) chk($sformatf("row%0d InstAddr", i), InstAddr, tbl[i].e_addr);
         @(posedge clk); #1;
         chk($sformatf("row%0d IFID_Valid", i), {31'h0, IFID_Valid}, {31'h0, tbl[i].e_v});
         chk($sformatf("row%0d IFID_Instruction", i), IFID_Instruction, tbl[i].e_ins);
         if (tbl[i].e_v) chk($sformatf("row%0d IFID_PC", i), IFID_PC, tbl[i].e_pc);
      end

      // Streaming with a 1-cycle memory that returns the address as data.
      clear_inputs();
      reset = 0;
      @(posedge clk); #1;
      reset = 1;
      for (int c = 0; c < 4; c++) begin
         #2;
         req_s = InstReq; addr_s = InstAddr;
         @(posedge clk); #1;
         InstValid = req_s; InstData = addr_s;
         if (c == 0) begin
            chk("stream first bubble", {31'h0, IFID_Valid}, 32'h0);
         end else begin
            chk($sformatf("stream%0d IFID_Valid", c), {31'h0, IFID_Valid}, 32'h1);
            chk($sformatf("stream%0d IFID_PC", c), IFID_PC, 32'h80000000 + 32'(4 * (c - 1)));
            chk($sformatf("stream%0d IFID_Instruction", c), IFID_Instruction, 32'h80000000 + 32'(4 * (c - 1)));
         end
      end

      // Mid-flight reset while WAIT: outputs clear at once, stale response is ignored.
      InstValid = 0;
      #2;
      reset = 0;
      #1;
      chk("midreset InstReq", {31'h0, InstReq}, 32'h0);
      chk("midreset IFID_Valid", {31'h0, IFID_Valid}, 32'h0);
      chk("midreset IFID_PC", IFID_PC, 32'h0);
      chk("midreset IFID_Instruction", IFID_Instruction, 32'h0);
      @(posedge clk); #1;
      InstValid = 1; InstData = 32'h8000000C;
      #2;
      reset = 1;
      #1;
      chk("postreset InstReq", {31'h0, InstReq}, 32'h1);
      chk("postreset InstAddr", InstAddr, 32'h80000000);
      @(posedge clk); #1;
      chk("stale ignored IFID_Valid", {31'h0, IFID_Valid}, 32'h0);
      InstValid = 1; InstData = 32'h80000000;
      #2;
      @(posedge clk); #1;
      InstValid = 0;
      chk("refetch IFID_Valid", {31'h0, IFID_Valid}, 32'h1);
      chk("refetch IFID_PC", IFID_PC, 32'h80000000);
      chk("refetch IFID_Instruction", IFID_Instruction, 32'h80000000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
